// File: rtl/reset_sequencer.sv
// reset_sequencer: turns a raw asynchronous reset into ordered, clock-synchronous per-stage resets.
// Optional watchdog (auto soft restart when not kicked) is enabled by defining RESET_SEQUENCER_WDT_EN.
module reset_sequencer #(
  parameter int STAGES      = 3,
  parameter int HOLD_CYCLES = 15,
  parameter int GAP_CYCLES  = 4,
  parameter int WDT_CYCLES  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              soft_req,
  input  logic              wdt_kick,
  output logic [STAGES-1:0] rst_out,
  output logic              done,
  output logic              wdt_fired
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int WW = $clog2(WDT_CYCLES + 1);

  localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0]     GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [STAGES-1:0] ALL_SET   = {STAGES{1'b1}};
  localparam logic [STAGES-1:0] ALL_CLR   = {STAGES{1'b0}};

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [1:0]        sync_r, sync_s;
  logic [HW-1:0]     hcnt_r, hcnt_s;
  logic [GW-1:0]     gcnt_r, gcnt_s;
  logic [STAGES-1:0] rst_r, rst_s;
  logic              done_r, done_s;
  logic              timeout_s;

`ifdef RESET_SEQUENCER_WDT_EN
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

  logic [WW-1:0] wcnt_r, wcnt_s;
  logic          fired_r;

  // Timeout only when nothing of higher priority (soft_req, kick) is present this edge
  always_comb begin
    if ((state_r == ST_DONE) && !soft_req && !wdt_kick && (wcnt_r == WDT_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Watchdog counter runs only in DONE; kicks clear it
  always_comb begin
    wcnt_s = {WW{1'b0}};
    if ((state_r == ST_DONE) && !soft_req && !timeout_s) begin
      if (wdt_kick) begin
        wcnt_s = {WW{1'b0}};
      end else begin
        wcnt_s = wcnt_r + WW'(1);
      end
    end else begin
      wcnt_s = {WW{1'b0}};
    end
  end

  // Watchdog counter and one-cycle fired flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_r  <= {WW{1'b0}};
      fired_r <= 1'b0;
    end else begin
      wcnt_r  <= wcnt_s;
      fired_r <= timeout_s;
    end
  end

  assign wdt_fired = fired_r;
`else
  logic [WW:0] wdt_unused_s;

  assign wdt_unused_s = {wdt_kick, {WW{1'b0}}};
  assign timeout_s    = 1'b0;
  assign wdt_fired    = 1'b0;
`endif

  // Next-state and next-output logic; a restart wins over normal sequencing
  always_comb begin
    state_s = state_r;
    sync_s  = {sync_r[0], 1'b0};
    hcnt_s  = hcnt_r;
    gcnt_s  = gcnt_r;
    rst_s   = rst_r;
    done_s  = done_r;
    if ((soft_req && (state_r != ST_SYNC)) || timeout_s) begin
      state_s = ST_HOLD;
      hcnt_s  = {HW{1'b0}};
      gcnt_s  = {GW{1'b0}};
      rst_s   = ALL_SET;
      done_s  = 1'b0;
    end else begin
      case (state_r)
        ST_SYNC: begin
          hcnt_s = {HW{1'b0}};
          gcnt_s = {GW{1'b0}};
          // The edge that clears the second flop is the edge that enters HOLD
          if (sync_r != 2'b11) begin
            state_s = ST_HOLD;
          end else begin
            state_s = ST_SYNC;
          end
        end
        ST_HOLD: begin
          if (hcnt_r == HOLD_LAST) begin
            rst_s  = rst_r << 1'b1;
            hcnt_s = {HW{1'b0}};
            gcnt_s = {GW{1'b0}};
            if (rst_s == ALL_CLR) begin
              state_s = ST_DONE;
              done_s  = 1'b1;
            end else begin
              state_s = ST_RELEASE;
            end
          end else begin
            hcnt_s = hcnt_r + HW'(1);
          end
        end
        ST_RELEASE: begin
          // Stages release low-to-high, so a left shift frees the next one
          if (gcnt_r == GAP_LAST) begin
            rst_s  = rst_r << 1'b1;
            gcnt_s = {GW{1'b0}};
            if (rst_s == ALL_CLR) begin
              state_s = ST_DONE;
              done_s  = 1'b1;
            end else begin
              state_s = ST_RELEASE;
            end
          end else begin
            gcnt_s = gcnt_r + GW'(1);
          end
        end
        ST_DONE: begin
          state_s = ST_DONE;
        end
        default: begin
          state_s = ST_SYNC;
          sync_s  = 2'b11;
          hcnt_s  = {HW{1'b0}};
          gcnt_s  = {GW{1'b0}};
          rst_s   = ALL_SET;
          done_s  = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_SYNC;
      sync_r  <= 2'b11;
      hcnt_r  <= {HW{1'b0}};
      gcnt_r  <= {GW{1'b0}};
      rst_r   <= ALL_SET;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sync_r  <= sync_s;
      hcnt_r  <= hcnt_s;
      gcnt_r  <= gcnt_s;
      rst_r   <= rst_s;
      done_r  <= done_s;
    end
  end

  assign rst_out = rst_r;
  assign done    = done_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues expected output changes, a monitor
// pops one entry per observed output change and checks both value and edge number.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       soft_req;
  logic       wdt_kick;
  logic [2:0] rst_out;
  logic       done;
  logic       wdt_fired;

  reset_sequencer #(
    .STAGES(3), .HOLD_CYCLES(15), .GAP_CYCLES(4), .WDT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .soft_req(soft_req), .wdt_kick(wdt_kick),
    .rst_out(rst_out), .done(done), .wdt_fired(wdt_fired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] rst;
    logic       done;
    logic       fired;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   base = 0;
  bit   kick_en = 1'b1;
  int   kick_ph = 0;

  // edge counter: value N between rising edge N and edge N+1
  always @(posedge clk) cyc = cyc + 1;

  task automatic push(input int c, input logic [2:0] r, input logic d, input logic f);
    exp_t e;
    e.cyc = c; e.rst = r; e.done = d; e.fired = f;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one-cycle kick every 7 edges while enabled
  initial begin
    wdt_kick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      kick_ph  = (kick_ph == 6) ? 0 : kick_ph + 1;
      wdt_kick = kick_en && (kick_ph == 0);
    end
  end

  // monitor: every output change must match the head of the queue
  bit         seen = 1'b0;
  logic [4:0] prev;
  always @(negedge clk) begin
    logic [4:0] cur;
    exp_t       e;
    cur = {rst_out, done, wdt_fired};
    if (!seen || (cur != prev)) begin
      seen = 1'b1;
      prev = cur;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_change edge=%0d got rst_out=%b done=%b wdt_fired=%b, required no change",
                 cyc, rst_out, done, wdt_fired);
      end else begin
        e = exp_q.pop_front();
        if ((e.cyc != cyc) || (e.rst !== rst_out) || (e.done !== done) || (e.fired !== wdt_fired)) begin
          miscompares++;
          $display("FAIL output_change got edge=%0d rst_out=%b done=%b wdt_fired=%b, required edge=%0d rst_out=%b done=%b wdt_fired=%b",
                   cyc, rst_out, done, wdt_fired, e.cyc, e.rst, e.done, e.fired);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL time_limit edge=%0d, required run to end well before this", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    reset    = 1'b0;
    soft_req = 1'b0;
    push(1, 3'b111, 1'b0, 1'b0);
    #2 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    base = cyc;

    // first release, interrupted by async reset after edge 22
    push(base + 17, 3'b110, 1'b0, 1'b0);
    push(base + 21, 3'b100, 1'b0, 1'b0);
    wait_cyc(base + 22);
    reset = 1'b1;
    push(base + 22, 3'b111, 1'b0, 1'b0);
    wait_cyc(base + 25);
    reset = 1'b0;
    base = cyc;

    // full default sequence
    push(base + 17, 3'b110, 1'b0, 1'b0);
    push(base + 21, 3'b100, 1'b0, 1'b0);
    push(base + 25, 3'b000, 1'b1, 1'b0);

    // soft_req pulse sampled on edge 40
    wait_cyc(base + 39);
    soft_req = 1'b1;
    push(base + 40, 3'b111, 1'b0, 1'b0);
    wait_cyc(base + 40);
    soft_req = 1'b0;
    push(base + 55, 3'b110, 1'b0, 1'b0);
    push(base + 59, 3'b100, 1'b0, 1'b0);
    push(base + 63, 3'b000, 1'b1, 1'b0);

    // soft_req held high on edges 70..79
    wait_cyc(base + 69);
    soft_req = 1'b1;
    push(base + 70, 3'b111, 1'b0, 1'b0);
    wait_cyc(base + 79);
    soft_req = 1'b0;
    push(base + 94, 3'b110, 1'b0, 1'b0);
    push(base + 98, 3'b100, 1'b0, 1'b0);
    push(base + 102, 3'b000, 1'b1, 1'b0);

    // fresh reset with kicks stopped
    wait_cyc(base + 110);
    kick_en = 1'b0;
    reset = 1'b1;
    push(base + 110, 3'b111, 1'b0, 1'b0);
    wait_cyc(base + 113);
    reset = 1'b0;
    base = cyc;
    push(base + 17, 3'b110, 1'b0, 1'b0);
    push(base + 21, 3'b100, 1'b0, 1'b0);
    push(base + 25, 3'b000, 1'b1, 1'b0);
`ifdef RESET_SEQUENCER_WDT_EN
    push(base + 33, 3'b111, 1'b0, 1'b1);
    push(base + 34, 3'b111, 1'b0, 1'b0);
    push(base + 48, 3'b110, 1'b0, 1'b0);
    push(base + 52, 3'b100, 1'b0, 1'b0);
    push(base + 56, 3'b000, 1'b1, 1'b0);
    wait_cyc(base + 60);
`else
    wait_cyc(base + 80);
`endif
    @(negedge clk);
    #1;

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_changes got %0d unobserved, required 0 (next edge=%0d rst_out=%b)",
               exp_q.size(), exp_q[0].cyc, exp_q[0].rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
